// File: rtl/inst_fetch_unit_if.sv
// Groups the fetch-stage signals: the ROM port, the redirect and stall inputs, and the decode outputs.
// Ports: InstNum/RomData is the ROM address and data, stall/redirect_* come from later stages, and if_*/halted/fault go to decode.
// The master modport is the fetch unit. The slave modport is the surrounding core or testbench.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] InstNum;
  logic [31:0]       RomData;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus4;
  logic              halted;
  logic              fault;

  modport master (
    output InstNum, if_valid, if_inst, if_pc, if_pc_plus4, halted, fault,
    input  RomData, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  InstNum, if_valid, if_inst, if_pc, if_pc_plus4, halted, fault,
    output RomData, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM, and registers the fetched word for decode.
// Latency: a word presented on InstNum in cycle n shows up on if_inst in cycle n+1. A redirect costs a one-cycle bubble.
// Backpressure: stall holds the PC and instruction register. A redirect overrides stall. A fault freezes everything until reset.
// Ports: clk, rst_n (async active-low), and bus (the fetch-side modport of inst_fetch_unit_if).
module inst_fetch_unit #(
  parameter int                ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h00,
  parameter logic [ADDR_W-1:0] PROG_END = 'h4C,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_unit_if.master  bus
);

  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic [31:0]       ir_q,       ir_d;
  logic [ADDR_W-1:0] ir_pc_q,    ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q,   halted_d;
  logic              fault_q,    fault_d;

  logic redirect_misaligned;
  assign redirect_misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  // Next-state logic. The branch order below is the priority order.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;

    if (fault_q) begin
      // Frozen. ir_valid was already cleared on the faulting edge.
    end else if (redirect_misaligned) begin
      fault_d    = 1'b1;
      halted_d   = 1'b1;
      ir_valid_d = 1'b0;
    end else if (bus.redirect_valid) begin
      // Flush the wrong-path word. An out-of-range target halts immediately.
      pc_d       = bus.redirect_pc;
      ir_valid_d = 1'b0;
      halted_d   = (bus.redirect_pc >= PROG_END);
    end else if (bus.stall) begin
      // Hold everything while decode is busy.
    end else if (pc_q >= PROG_END) begin
      // ROM contents are undefined past the program, so RomData is not sampled.
      halted_d   = 1'b1;
      ir_valid_d = 1'b0;
    end else begin
      ir_d       = bus.RomData;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INST;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.InstNum     = pc_q;
  assign bus.if_valid    = ir_valid_q;
  assign bus.if_inst     = ir_valid_q ? ir_q : NOP_INST;
  assign bus.if_pc       = ir_pc_q;
  assign bus.if_pc_plus4 = ir_pc_q + ADDR_W'(4);
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [31:0] rom [0:31];

  inst_fetch_unit_if #(.ADDR_W(7)) bus ();

  inst_fetch_unit #(
    .ADDR_W   (7),
    .RESET_PC (7'h00),
    .PROG_END (7'h4C),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model. Addresses past the program read as X, so sampling there would be visible.
  always_comb begin
    if (bus.InstNum < 7'h4C) bus.RomData = rom[bus.InstNum[6:2]];
    else                     bus.RomData = 32'hxxxx_xxxx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] inst,
                         input logic [6:0] pc, input logic [6:0] inum);
    chk({tag, ".if_valid"}, 32'(bus.if_valid), 32'(vld));
    chk({tag, ".if_inst"},  bus.if_inst,       inst);
    chk({tag, ".if_pc"},    32'(bus.if_pc),    32'(pc));
    chk({tag, ".InstNum"},  32'(bus.InstNum),  32'(inum));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 | i;
    rom[0]  = 32'h0045_0693;
    rom[1]  = 32'h0010_0713;
    rom[2]  = 32'h00b7_6463;
    rom[3]  = 32'h0000_8067;
    rom[4]  = 32'h0006_a803;
    rom[5]  = 32'h0006_8613;
    rom[6]  = 32'h00d7_1463;
    rom[7]  = 32'hffc6_2883;
    rom[18] = 32'hfc1f_f06f;

    rst_n              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 7'h00;
    tick();
    tick();

    // Reset values
    chk_out("rst", 1'b0, 32'h0000_0013, 7'h00, 7'h00);
    chk("rst.plus4",  32'(bus.if_pc_plus4), 32'd4);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.fault",  32'(bus.fault),  32'd0);

    // Straight-line run
    rst_n = 1'b1;
    tick();
    chk_out("run0", 1'b1, 32'h0045_0693, 7'h00, 7'h04);
    tick();
    chk_out("run1", 1'b1, 32'h0010_0713, 7'h04, 7'h08);
    tick();
    chk_out("run2", 1'b1, 32'h00b7_6463, 7'h08, 7'h0C);

    // Redirect to 0x10 while if_pc = 8
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'h10;
    tick();
    bus.redirect_valid = 1'b0;
    chk_out("redir_bubble", 1'b0, 32'h0000_0013, 7'h08, 7'h10);
    tick();
    chk_out("redir_tgt", 1'b1, 32'h0006_a803, 7'h10, 7'h14);
    chk("redir_tgt.plus4", 32'(bus.if_pc_plus4), 32'h14);

    // Stall for three cycles
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 1'b1, 32'h0006_a803, 7'h10, 7'h14);
    end
    bus.stall = 1'b0;
    tick();
    chk_out("stall_rel", 1'b1, 32'h0006_8613, 7'h14, 7'h18);

    // A redirect asserted together with stall wins
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'h1C;
    tick();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    chk_out("redir_stall", 1'b0, 32'h0000_0013, 7'h14, 7'h1C);
    tick();
    chk_out("redir_stall_tgt", 1'b1, 32'hffc6_2883, 7'h1C, 7'h20);

    // Halt at end of program
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'h48;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    chk_out("last", 1'b1, 32'hfc1f_f06f, 7'h48, 7'h4C);
    chk("last.halted", 32'(bus.halted), 32'd0);
    tick();
    chk_out("halt", 1'b0, 32'h0000_0013, 7'h48, 7'h4C);
    chk("halt.halted", 32'(bus.halted), 32'd1);
    tick();
    chk("halt_hold.InstNum", 32'(bus.InstNum), 32'h4C);
    chk("halt_hold.halted",  32'(bus.halted),  32'd1);

    // Redirect out of the halted state
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'h00;
    tick();
    bus.redirect_valid = 1'b0;
    chk("resume.halted", 32'(bus.halted), 32'd0);
    chk("resume.valid",  32'(bus.if_valid), 32'd0);
    tick();
    chk_out("resume", 1'b1, 32'h0045_0693, 7'h00, 7'h04);

    // Misaligned redirect
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 7'h12;
    tick();
    chk("fault.fault",   32'(bus.fault),   32'd1);
    chk("fault.halted",  32'(bus.halted),  32'd1);
    chk("fault.valid",   32'(bus.if_valid), 32'd0);
    chk("fault.InstNum", 32'(bus.InstNum), 32'h04);
    bus.redirect_pc = 7'h08;
    bus.stall       = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    tick();
    chk("fault_sticky.fault",   32'(bus.fault),   32'd1);
    chk("fault_sticky.InstNum", 32'(bus.InstNum), 32'h04);
    chk("fault_sticky.valid",   32'(bus.if_valid), 32'd0);

    // Reset clears the fault
    rst_n = 1'b0;
    #1;
    chk("fault_rst.fault",  32'(bus.fault),  32'd0);
    chk("fault_rst.halted", 32'(bus.halted), 32'd0);
    tick();
    rst_n = 1'b1;

    // Run to if_pc = 0x24, then apply an asynchronous reset between edges
    for (int i = 0; i < 10; i++) tick();
    chk_out("pre_arst", 1'b1, 32'h1000_0009, 7'h24, 7'h28);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 32'h0000_0013, 7'h00, 7'h00);
    chk("arst.plus4", 32'(bus.if_pc_plus4), 32'd4);
    chk("arst.halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("post_arst", 1'b1, 32'h0045_0693, 7'h00, 7'h04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
